mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: RETIRE_W, 32, width of retired-instruction counter.
REQ-002 Port: CLK  in  1  system clock; all state updates on rising edge.
REQ-003 Port: nRST  in  1  reset, synchronous, active-low.
REQ-004 Port: mem_valid  in  1  upstream slot holds a real instruction.
REQ-005 Port: mem_regwrite  in  1  instruction writes a register.
REQ-006 Port: mem_wsel  in  5  destination register index.
REQ-007 Port: mem_wbsrc  in  2  writeback source: 0 ALU, 1 load data, 2 PC+4, 3 LUI.
REQ-008 Port: mem_aluout  in  32  ALU result.
REQ-009 Port: mem_dload  in  32  load data from memory.
REQ-010 Port: mem_npc  in  32  PC+4 for JAL.
REQ-011 Port: mem_imm16  in  16  immediate for LUI.
REQ-012 Port: mem_halt  in  1  instruction is HALT.
REQ-013 Port: wb_en  in  1  advance stage (0 = stall/hold).
REQ-014 Port: wb_flush  in  1  squash incoming slot.
REQ-015 Port: rf_WEN  out  1  register-file write enable.
REQ-016 Port: rf_wsel  out  5  register-file write index.
REQ-017 Port: rf_wdat  out  32  register-file write data.
REQ-018 Port: halt  out  1  sticky halt flag.
REQ-019 Port: retired_cnt  out  RETIRE_W  count of instructions retired.

Function
REQ-020 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-021 Per rising edge, priority SHALL be: reset > halt held > wb_flush > wb_en capture > hold.
REQ-022 wb_flush=1 SHALL clear the latched valid bit regardless of wb_en; the counter SHALL NOT increment.
REQ-023 wb_en=1, wb_flush=0 SHALL latch valid, regwrite, wsel, halt-bit and the selected write data.
REQ-024 wb_en=0, wb_flush=0 SHALL hold all latched state unchanged; no double-retire of a held slot.
REQ-025 Write data SHALL be selected at capture: src 0 -> mem_aluout, 1 -> mem_dload, 2 -> mem_npc, 3 -> {mem_imm16, 16'h0000}.
REQ-026 rf_WEN SHALL equal latched valid AND regwrite AND (wsel != 0) AND NOT latched halt-bit; it SHALL be 0 for wsel=0.
REQ-027 rf_wsel/rf_wdat SHALL show latched values even when rf_WEN=0.
REQ-028 Latency: an instruction captured at edge N SHALL drive rf_WEN/rf_wdat from edge N until the next edge; the downstream falling-edge write commits it in that cycle.
REQ-029 retired_cnt SHALL increment by 1 on each capture edge with mem_valid=1 (HALT included), saturating at all-ones.
REQ-030 Capture of a valid instruction with mem_halt=1 SHALL set halt at that edge; halt SHALL stay 1 until reset.
REQ-031 While halt=1, further captures SHALL be ignored: valid held 0, rf_WEN=0, retired_cnt frozen.
REQ-032 A HALT slot SHALL never write a register, even if mem_regwrite=1.
REQ-033 Captured mem_valid=0 SHALL produce rf_WEN=0 and no counter change.

Reset
REQ-034 nRST=0 at a rising edge SHALL clear valid, rf_WEN, rf_wsel, rf_wdat, halt, retired_cnt to 0, overriding wb_en/wb_flush, including mid-stall and after halt.
REQ-035 First capture after reset SHALL occur on the first rising edge with nRST=1 and wb_en=1.

Verification
REQ-036 Reset, then capture valid regwrite wsel=5 src=0 aluout=0x1234_5678 -> next cycle rf_WEN=1, rf_wsel=5, rf_wdat=0x12345678, retired_cnt=1.
REQ-037 Capture src=3 imm16=0xBEEF wsel=8, then src=2 npc=0x0000_0044 wsel=31 -> rf_wdat 0xBEEF0000, then 0x00000044, rf_WEN=1 both.
REQ-038 Valid regwrite wsel=0 aluout=0xFFFF_FFFF -> rf_WEN=0, retired_cnt increments.
REQ-039 Capture valid instr, then wb_en=0 three cycles with changing inputs -> outputs/counter unchanged; then wb_en=1 and wb_flush=1 together -> rf_WEN=0, counter unchanged.
REQ-040 Capture HALT with mem_regwrite=1 -> halt=1, rf_WEN=0, counter +1; subsequent valid captures -> no writes, counter frozen; nRST=0 one edge -> all outputs 0.
REQ-041 Preload retired_cnt near all-ones (RETIRE_W=4, 15 valid captures, then 2 more) -> retired_cnt stays 0xF.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the writeback slot, drives the register-file
// write port, keeps a sticky halt flag and a saturating retired-instruction count.
module mem_wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                mem_valid,
    input  logic                mem_regwrite,
    input  logic [4:0]          mem_wsel,
    input  logic [1:0]          mem_wbsrc,
    input  logic [31:0]         mem_aluout,
    input  logic [31:0]         mem_dload,
    input  logic [31:0]         mem_npc,
    input  logic [15:0]         mem_imm16,
    input  logic                mem_halt,
    input  logic                wb_en,
    input  logic                wb_flush,
    output logic                rf_WEN,
    output logic [4:0]          rf_wsel,
    output logic [31:0]         rf_wdat,
    output logic                halt,
    output logic [RETIRE_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_NPC  = 2'd2,
        SRC_LUI  = 2'd3
    } wbsrc_e;

    localparam logic [RETIRE_W-1:0] CNT_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};
    localparam logic [RETIRE_W-1:0] CNT_MAX = '1;

    logic        valid_q;
    logic        regwrite_q;
    logic        halt_bit_q;
    logic [31:0] wdat_sel;

    // NOTE: default assignment first so every path drives wdat_sel and no latch is inferred.
    always_comb begin
        wdat_sel = mem_aluout;
        case (wbsrc_e'(mem_wbsrc))
            SRC_ALU:  wdat_sel = mem_aluout;
            SRC_LOAD: wdat_sel = mem_dload;
            SRC_NPC:  wdat_sel = mem_npc;
            SRC_LUI:  wdat_sel = {mem_imm16, 16'h0000};
            default:  wdat_sel = mem_aluout;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            halt_bit_q  <= 1'b0;
            rf_wsel     <= '0;
            rf_wdat     <= '0;
            halt        <= 1'b0;
            retired_cnt <= '0;
        end else if (halt) begin
            // Halted: the slot is dead until reset; payload and count are frozen.
            valid_q <= 1'b0;
        end else if (wb_flush) begin
            valid_q <= 1'b0;
        end else if (wb_en) begin
            valid_q    <= mem_valid;
            regwrite_q <= mem_regwrite;
            halt_bit_q <= mem_halt;
            rf_wsel    <= mem_wsel;
            rf_wdat    <= wdat_sel;
            if (mem_valid && retired_cnt != CNT_MAX)
                retired_cnt <= retired_cnt + CNT_ONE;
            if (mem_valid && mem_halt)
                halt <= 1'b1;
        end
    end

    // Decoded purely from latched state, so no input reaches the write enable combinationally.
    assign rf_WEN = valid_q & regwrite_q & (rf_wsel != 5'd0) & ~halt_bit_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, halt/saturation
// sequences, and randomized traffic against a behavioural model.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        mem_valid, mem_regwrite, mem_halt, wb_en, wb_flush;
    logic [4:0]  mem_wsel;
    logic [1:0]  mem_wbsrc;
    logic [31:0] mem_aluout, mem_dload, mem_npc;
    logic [15:0] mem_imm16;

    logic        rf_WEN, halt;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [31:0] retired_cnt;
    logic        rf_WEN4, halt4;
    logic [4:0]  rf_wsel4;
    logic [31:0] rf_wdat4;
    logic [3:0]  retired_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_wb_stage #(.RETIRE_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_wsel(mem_wsel), .mem_wbsrc(mem_wbsrc), .mem_aluout(mem_aluout),
        .mem_dload(mem_dload), .mem_npc(mem_npc), .mem_imm16(mem_imm16),
        .mem_halt(mem_halt), .wb_en(wb_en), .wb_flush(wb_flush),
        .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .halt(halt),
        .retired_cnt(retired_cnt)
    );

    mem_wb_stage #(.RETIRE_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_wsel(mem_wsel), .mem_wbsrc(mem_wbsrc), .mem_aluout(mem_aluout),
        .mem_dload(mem_dload), .mem_npc(mem_npc), .mem_imm16(mem_imm16),
        .mem_halt(mem_halt), .wb_en(wb_en), .wb_flush(wb_flush),
        .rf_WEN(rf_WEN4), .rf_wsel(rf_wsel4), .rf_wdat(rf_wdat4), .halt(halt4),
        .retired_cnt(retired_cnt4)
    );

    typedef struct {
        logic        nrst, valid, rw, mhalt, en, flush;
        logic [4:0]  wsel;
        logic [1:0]  src;
        logic [31:0] alu, dload, npc;
        logic [15:0] imm;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        int          e_cnt;
    } vec_t;

    // 'data' lands only in the selected source; the others carry distinct junk.
    function automatic vec_t mk(input logic nrst, input logic valid, input logic rw,
                                input logic [4:0] wsel, input logic [1:0] src,
                                input logic [31:0] data, input logic mhalt,
                                input logic en, input logic flush, input logic e_wen,
                                input logic [4:0] e_wsel, input logic [31:0] e_wdat,
                                input int e_cnt);
        vec_t v;
        v.nrst = nrst; v.valid = valid; v.rw = rw; v.wsel = wsel; v.src = src;
        v.mhalt = mhalt; v.en = en; v.flush = flush;
        v.alu = 32'hDEAD_0001; v.dload = 32'hDEAD_0002; v.npc = 32'hDEAD_0003;
        v.imm = 16'hD00D;
        case (src)
            2'd0: v.alu = data;
            2'd1: v.dload = data;
            2'd2: v.npc = data;
            default: v.imm = data[15:0];
        endcase
        v.e_wen = e_wen; v.e_wsel = e_wsel; v.e_wdat = e_wdat; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        nRST = v.nrst; mem_valid = v.valid; mem_regwrite = v.rw; mem_wsel = v.wsel;
        mem_wbsrc = v.src; mem_aluout = v.alu; mem_dload = v.dload; mem_npc = v.npc;
        mem_imm16 = v.imm; mem_halt = v.mhalt; wb_en = v.en; wb_flush = v.flush;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat4(input int c);
        return (c > 15) ? 32'd15 : c;
    endfunction

    task automatic check_all(input string tag, input logic e_wen, input logic [4:0] e_wsel,
                             input logic [31:0] e_wdat, input logic e_halt, input int e_cnt);
        check({tag, ".rf_WEN"}, {31'b0, rf_WEN}, {31'b0, e_wen});
        check({tag, ".rf_wsel"}, {27'b0, rf_wsel}, {27'b0, e_wsel});
        check({tag, ".rf_wdat"}, rf_wdat, e_wdat);
        check({tag, ".halt"}, {31'b0, halt}, {31'b0, e_halt});
        check({tag, ".retired_cnt"}, retired_cnt, e_cnt);
        check({tag, ".retired_cnt4"}, {28'b0, retired_cnt4}, sat4(e_cnt));
    endtask

    vec_t tbl[$];
    vec_t v;

    // Behavioural reference state for the random phase.
    logic        m_wen, m_halt;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;
    int          m_cnt;

    initial begin
        v = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        @(negedge CLK);

        //        nrst valid rw wsel src data          hlt en fl  wen wsel  wdat          cnt
        tbl.push_back(mk(0, 1, 1,  5, 0, 32'h1111_1111, 0, 1, 0,  0,  0, 32'h0000_0000, 0));
        tbl.push_back(mk(1, 1, 1,  5, 0, 32'h1234_5678, 0, 1, 0,  1,  5, 32'h1234_5678, 1));
        tbl.push_back(mk(1, 1, 1,  8, 3, 32'h0000_BEEF, 0, 1, 0,  1,  8, 32'hBEEF_0000, 2));
        tbl.push_back(mk(1, 1, 1, 31, 2, 32'h0000_0044, 0, 1, 0,  1, 31, 32'h0000_0044, 3));
        tbl.push_back(mk(1, 1, 1,  7, 1, 32'hCAFE_F00D, 0, 1, 0,  1,  7, 32'hCAFE_F00D, 4));
        tbl.push_back(mk(1, 1, 1,  0, 0, 32'hFFFF_FFFF, 0, 1, 0,  0,  0, 32'hFFFF_FFFF, 5));
        tbl.push_back(mk(1, 1, 1,  3, 0, 32'hA5A5_A5A5, 0, 1, 0,  1,  3, 32'hA5A5_A5A5, 6));
        tbl.push_back(mk(1, 1, 1,  9, 0, 32'h0000_0009, 0, 0, 0,  1,  3, 32'hA5A5_A5A5, 6));
        tbl.push_back(mk(1, 0, 0, 10, 1, 32'h0000_000A, 0, 0, 0,  1,  3, 32'hA5A5_A5A5, 6));
        tbl.push_back(mk(1, 1, 1, 11, 3, 32'h0000_000B, 1, 0, 0,  1,  3, 32'hA5A5_A5A5, 6));
        tbl.push_back(mk(1, 1, 1, 12, 0, 32'h0000_0011, 0, 1, 1,  0,  3, 32'hA5A5_A5A5, 6));
        tbl.push_back(mk(1, 0, 1,  4, 0, 32'h0000_0022, 0, 1, 0,  0,  4, 32'h0000_0022, 6));
        tbl.push_back(mk(1, 1, 0,  6, 0, 32'h0000_0033, 0, 1, 0,  0,  6, 32'h0000_0033, 7));
        tbl.push_back(mk(1, 1, 1, 13, 0, 32'h0000_0044, 0, 1, 0,  1, 13, 32'h0000_0044, 8));
        tbl.push_back(mk(1, 1, 1, 14, 0, 32'h0000_0055, 0, 0, 1,  0, 13, 32'h0000_0044, 8));
        tbl.push_back(mk(0, 1, 1, 15, 0, 32'h0000_0066, 0, 0, 0,  0,  0, 32'h0000_0000, 0));
        tbl.push_back(mk(1, 1, 1,  2, 0, 32'h0000_0005, 0, 1, 0,  1,  2, 32'h0000_0005, 1));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].e_wen, tbl[i].e_wsel, tbl[i].e_wdat,
                      1'b0, tbl[i].e_cnt);
        end

        // HALT with regwrite: flag set, no write, counted once.
        drive(mk(1, 1, 1, 9, 0, 32'h0000_0077, 1, 1, 0, 0, 0, 0, 0));
        step();
        check_all("halt_cap", 1'b0, 5'd9, 32'h0000_0077, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 1, 1, 5'(10 + i), 0, 32'h100 + i, 0, 1, 0, 0, 0, 0, 0));
            step();
            check($sformatf("halted%0d.rf_WEN", i), {31'b0, rf_WEN}, 32'd0);
            check($sformatf("halted%0d.halt", i), {31'b0, halt}, 32'd1);
            check($sformatf("halted%0d.cnt", i), retired_cnt, 32'd2);
        end
        drive(mk(0, 1, 1, 10, 0, 32'h0000_0123, 0, 1, 0, 0, 0, 0, 0));
        step();
        check_all("halt_reset", 1'b0, 5'd0, 32'd0, 1'b0, 0);

        // Saturation of the 4-bit counter: 15 captures reach 0xF, two more stay there.
        for (int i = 0; i < 17; i++) begin
            drive(mk(1, 1, 1, 1, 0, i, 0, 1, 0, 0, 0, 0, 0));
            step();
            if (i == 14) check("sat_reach", {28'b0, retired_cnt4}, 32'd15);
        end
        check("sat_hold4", {28'b0, retired_cnt4}, 32'd15);
        check("sat_wide", retired_cnt, 32'd17);

        // Randomized traffic against the behavioural model.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        m_wen = 0; m_halt = 0; m_wsel = 0; m_wdat = 0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] sel;
            nRST         = ($urandom_range(0, 39) != 0);
            mem_valid    = ($urandom_range(0, 3) != 0);
            mem_regwrite = ($urandom_range(0, 3) != 0);
            mem_wsel     = 5'($urandom_range(0, 31));
            mem_wbsrc    = 2'($urandom_range(0, 3));
            mem_aluout   = $urandom;
            mem_dload    = $urandom;
            mem_npc      = $urandom;
            mem_imm16    = 16'($urandom);
            mem_halt     = ($urandom_range(0, 24) == 0);
            wb_en        = ($urandom_range(0, 3) != 0);
            wb_flush     = ($urandom_range(0, 7) == 0);

            sel = (mem_wbsrc == 2'd0) ? mem_aluout :
                  (mem_wbsrc == 2'd1) ? mem_dload :
                  (mem_wbsrc == 2'd2) ? mem_npc : {mem_imm16, 16'h0000};
            if (!nRST) begin
                m_wen = 0; m_halt = 0; m_wsel = 0; m_wdat = 0; m_cnt = 0;
            end else if (m_halt || wb_flush) begin
                m_wen = 0;
            end else if (wb_en) begin
                m_wsel = mem_wsel;
                m_wdat = sel;
                m_wen  = mem_valid && mem_regwrite && mem_wsel != 0 && !mem_halt;
                if (mem_valid) m_cnt++;
                if (mem_valid && mem_halt) m_halt = 1;
            end
            step();
            check_all($sformatf("rnd%0d", i), m_wen, m_wsel, m_wdat, m_halt, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
